pipe_hazard_scoreboard: RTL and testbench
=========================================

// Module: pipe_hazard_scoreboard
// PURPOSE
//  Parametrised scoreboard that tracks in-flight destination registers across the execute..writeback stages of the RISC-V pipeline.
//  Generates the decode-stage stall, per-operand forwarding select and forwarded data, and the flush pulses on a taken branch.
//  Supersedes the fixed one-load-interlock hazard detection and fixed EX/MEM/WB forwarding with variable depth and load latency.
//  Sits beside the ID/EX register; driven by decode fields and by the result bus of each later stage.
// PARAMETERS
//  XLEN        64  datapath width of forwarded values
//  RA_W        5   register-address width (x0 is hardwired zero, never tracked)
//  NSTG        3   tracked stages after decode (1=EX, 2=MEM, 3=WB); legal range 2..8
//  LOAD_LAT    1   cycles after EX before load data is valid; a load is ready at stage >= 1+LOAD_LAT; must be <= NSTG-1
//  BR_STG      2   stage whose redirect input is a taken branch/jump; legal range 1..NSTG
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            synchronous, active-low reset
//  id_valid     in   1            decode holds a real instruction
//  id_rs1       in   RA_W         source register 1
//  id_rs2       in   RA_W         source register 2
//  id_use_rs1   in   1            instruction reads rs1
//  id_use_rs2   in   1            instruction reads rs2
//  id_rd        in   RA_W         destination register
//  id_regwrite  in   1            instruction writes rd
//  id_is_load   in   1            instruction is a load
//  stg_data     in   NSTG*XLEN    result of stage k, at bits [k*XLEN-1 -: XLEN]
//  redirect     in   1            taken branch resolved in stage BR_STG
//  stall        out  1            hold PC and IF/ID; bubble into ID/EX
//  flush_ifid   out  1            squash IF/ID
//  flush_idex   out  1            squash ID/EX
//  fwd_sel1/2   out  SEL_W        0 = register file, k = stage k; SEL_W = $clog2(NSTG+1)
//  fwd_data1/2  out  XLEN         stg_data of the selected stage; 0 when sel = 0
// BEHAVIOUR
//  - Entry per stage: {vld, rd, ld}. Each clock, entries shift k -> k+1; the stage-NSTG entry retires.
//  - Stage 1 loads the decode entry if id_valid & id_regwrite & id_rd!=0 & !stall & !redirect. Otherwise it loads a bubble (vld=0).
//  - Match(k, rs) = vld[k] & rd[k]==rs & rs!=0. For each operand, the youngest (lowest k) match wins.
//  - An operand is ready at stage k when !ld[k] or k >= 1+LOAD_LAT.
//  - stall = id_valid & !redirect & (for some used operand, its winning match is not ready). stall is combinational.
//  - Forwarding: fwd_sel = winning k when ready, else 0. Stage NSTG matches are forwarded, which covers same-cycle regfile write-read.
//  - On redirect:
//      - flush_ifid = flush_idex = 1 in the same cycle;
//      - entries in stages 1..BR_STG-1 are invalidated at the clock edge (they shift in as bubbles);
//      - older entries are kept.
//  - redirect has priority over stall: stall is forced to 0 and flushes are asserted.
//  - Simultaneous stall and in-flight shift: older entries still advance. Only stage 1 receives the bubble.
//  - Reset (reset==0 at an edge): all vld = 0. Reset mid-operation drops every in-flight entry.
//    stall/flush/fwd_sel are combinational and therefore 0 after reset with idle inputs.
//  - Latency: decode entry visible in stage 1 one cycle after issue. Load-use bubble count = LOAD_LAT.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//    - adds outputs stall_cnt[31:0] and flush_cnt[31:0];
//    - counts cycles with stall=1 and with redirect=1;
//    - cleared by reset; saturate at 2^32-1 (no wrap).
//  Undefined: ports and counters absent; no other behavioural difference.
// STRUCTURE
//  - Package pipe_hazard_pkg:
//      - sb_entry_t struct {vld, rd, ld};
//      - FWD_RF = 0 select constant;
//      - function sel_width(nstg).
//  - Sub-module pipe_fwd_lookup (combinational youngest-match priority encoder + ready check).
//    Instantiated once per operand; the scoreboard itself owns the shift register, stall and flush logic.
// TESTING
//  - Default params, add x5 then add x6,x5,x1 back-to-back -> stall=0, fwd_sel1=1, fwd_data1=stg_data[EX].
//  - ld x5 then add x6,x5,x0 -> stall=1 for 1 cycle; next cycle stall=0, fwd_sel1=2 (MEM).
//    With LOAD_LAT=2 -> 2 stall cycles, then sel=3.
//  - x5 written in stages 1 and 3 simultaneously -> fwd_sel=1 (youngest). rd=x0 writer -> fwd_sel=0, stall=0.
//  - redirect with dependent load in stage 1 -> stall=0, flush_ifid=flush_idex=1, stage-1 entry invalid next cycle.
//  - reset=0 for 1 cycle with 3 valid entries -> next cycle all matches gone, fwd_sel=0, stall=0.
//  - HAZ_PERF_CNT_EN: 4 stall cycles and 2 redirects -> stall_cnt=4, flush_cnt=2; preload near max -> saturates at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// pipe_hazard_pkg: scoreboard entry type, regfile select constant and select-width helper
package pipe_hazard_pkg;
    localparam int RA_MAX = 8;
    localparam int FWD_RF = 0;
    typedef struct packed {
        logic              vld;
        logic [RA_MAX-1:0] rd;
        logic              ld;
    } sb_entry_t;
    function automatic int sel_width(input int nstg);
        return $clog2(nstg + 1);
    endfunction
endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// pipe_hazard_scoreboard_if: decode fields, stage results, redirect in; stall, flush, forwarding out
// HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt
interface pipe_hazard_scoreboard_if #(
    parameter int XLEN = 64,
    parameter int RA_W = 5,
    parameter int NSTG = 3
);
    import pipe_hazard_pkg::*;
    localparam int SEL_W = sel_width(NSTG);
    logic                 id_valid;
    logic [RA_W-1:0]      id_rs1;
    logic [RA_W-1:0]      id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [RA_W-1:0]      id_rd;
    logic                 id_regwrite;
    logic                 id_is_load;
    logic [NSTG*XLEN-1:0] stg_data;
    logic                 redirect;
    logic                 stall;
    logic                 flush_ifid;
    logic                 flush_idex;
    logic [SEL_W-1:0]     fwd_sel1;
    logic [SEL_W-1:0]     fwd_sel2;
    logic [XLEN-1:0]      fwd_data1;
    logic [XLEN-1:0]      fwd_data2;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]          stall_cnt;
    logic [31:0]          flush_cnt;
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load, stg_data, redirect,
        input  stall, flush_ifid, flush_idex, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load, stg_data, redirect,
        output stall, flush_ifid, flush_idex, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2, stall_cnt, flush_cnt
    );
`else
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load, stg_data, redirect,
        input  stall, flush_ifid, flush_idex, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load, stg_data, redirect,
        output stall, flush_ifid, flush_idex, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2
    );
`endif
endinterface

// File: rtl/pipe_hazard_scoreboard_fwd_lookup.sv
// pipe_fwd_lookup: youngest-match priority encoder over the scoreboard with load-readiness check
module pipe_fwd_lookup
    import pipe_hazard_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int RA_W     = 5,
    parameter int NSTG     = 3,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = sel_width(NSTG)
) (
    input  sb_entry_t [NSTG:1]    ents,
    input  logic [RA_W-1:0]       rs,
    input  logic [NSTG*XLEN-1:0]  stg_data,
    output logic [SEL_W-1:0]      sel,
    output logic [XLEN-1:0]       data,
    output logic                  pend
);
    always_comb begin
        sel  = SEL_W'(FWD_RF);
        pend = 1'b0;
        // oldest first so the youngest match overwrites
        for (int k = NSTG; k >= 1; k--) begin
            if (ents[k].vld && ents[k].rd == RA_MAX'(rs) && rs != '0) begin
                sel  = (!ents[k].ld || k >= 1 + LOAD_LAT) ? SEL_W'(k) : SEL_W'(FWD_RF);
                pend = ents[k].ld && k < 1 + LOAD_LAT;
            end
        end
        data = (sel == SEL_W'(FWD_RF)) ? '0 : stg_data[(int'(sel) - 1) * XLEN +: XLEN];
    end
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: in-flight rd tracking, decode stall, operand forwarding and branch flushes
// HAZ_PERF_CNT_EN adds saturating stall/redirect cycle counters
module pipe_hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int RA_W     = 5,
    parameter int NSTG     = 3,
    parameter int LOAD_LAT = 1,
    parameter int BR_STG   = 2
) (
    input logic                      clk,
    input logic                      reset,
    pipe_hazard_scoreboard_if.slave  bus
);
    sb_entry_t [NSTG:1] ents;
    logic pend1, pend2, stall, issue;
    pipe_fwd_lookup #(.XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .LOAD_LAT(LOAD_LAT)) u_op1 (
        .ents(ents), .rs(bus.id_rs1), .stg_data(bus.stg_data),
        .sel(bus.fwd_sel1), .data(bus.fwd_data1), .pend(pend1)
    );
    pipe_fwd_lookup #(.XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .LOAD_LAT(LOAD_LAT)) u_op2 (
        .ents(ents), .rs(bus.id_rs2), .stg_data(bus.stg_data),
        .sel(bus.fwd_sel2), .data(bus.fwd_data2), .pend(pend2)
    );
    assign stall = bus.id_valid && !bus.redirect && ((bus.id_use_rs1 && pend1) || (bus.id_use_rs2 && pend2));
    assign issue = bus.id_valid && bus.id_regwrite && bus.id_rd != '0 && !stall && !bus.redirect;
    assign bus.stall      = stall;
    assign bus.flush_ifid = bus.redirect;
    assign bus.flush_idex = bus.redirect;
    // entries younger than the branch stage become bubbles as they shift
    always_ff @(posedge clk) begin
        if (!reset) begin
            ents <= '0;
        end else begin
            ents[1] <= issue ? sb_entry_t'{vld: 1'b1, rd: RA_MAX'(bus.id_rd), ld: bus.id_is_load} : '0;
            for (int k = 2; k <= NSTG; k++)
                ents[k] <= (bus.redirect && k <= BR_STG) ? '0 : ents[k-1];
        end
    end
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= (stall && stall_cnt != '1) ? stall_cnt + 32'd1 : stall_cnt;
            flush_cnt <= (bus.redirect && flush_cnt != '1) ? flush_cnt + 32'd1 : flush_cnt;
        end
    end
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed + random checks of two scoreboards (LOAD_LAT 1 and 2) against a list-based model
module tb_pipe_hazard_scoreboard;
    import pipe_hazard_pkg::*;
    localparam int XLEN = 64, RA_W = 5, NSTG = 3, BR_STG = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG)) ia ();
    pipe_hazard_scoreboard_if #(.XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG)) ib ();

    pipe_hazard_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .LOAD_LAT(1), .BR_STG(BR_STG)) u_dut_a (
        .clk(clk), .reset(rst_n), .bus(ia.slave));
    pipe_hazard_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .LOAD_LAT(2), .BR_STG(BR_STG)) u_dut_b (
        .clk(clk), .reset(rst_n), .bus(ib.slave));

    // model: list of in-flight writers, each tagged with its current stage number
    typedef struct {int rd; bit ld; int stg;} rec_t;
    typedef rec_t rq_t[$];
    rq_t qa, qb;
    int nerr = 0, nchk = 0;
    bit c_v, c_u1, c_u2, c_rw, c_ld, c_redir;
    int c_rs1, c_rs2, c_rd;
    logic [NSTG*XLEN-1:0] stg;
    bit st_a, st_b;
    longint unsigned m_scnt = 0, m_fcnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input rq_t q, input int rs);
        int best = -1;
        foreach (q[i])
            if (rs != 0 && q[i].rd == rs && (best < 0 || q[i].stg < q[best].stg)) best = i;
        return best;
    endfunction

    function automatic void predict(input rq_t q, input int lat, output bit st, output int s1, output int s2);
        int w1 = winner(q, c_rs1), w2 = winner(q, c_rs2);
        bit p1 = w1 >= 0 && q[w1].ld && q[w1].stg < 1 + lat;
        bit p2 = w2 >= 0 && q[w2].ld && q[w2].stg < 1 + lat;
        s1 = (w1 < 0 || p1) ? 0 : q[w1].stg;
        s2 = (w2 < 0 || p2) ? 0 : q[w2].stg;
        st = c_v && !c_redir && ((c_u1 && p1) || (c_u2 && p2));
    endfunction

    function automatic rq_t advance(input rq_t q, input bit st);
        rq_t n;
        if (!rst_n) return n;
        foreach (q[i])
            if (!(c_redir && q[i].stg < BR_STG) && q[i].stg < NSTG)
                n.push_back('{rd: q[i].rd, ld: q[i].ld, stg: q[i].stg + 1});
        if (c_v && c_rw && c_rd != 0 && !st && !c_redir)
            n.push_back('{rd: c_rd, ld: c_ld, stg: 1});
        return n;
    endfunction

    function automatic logic [63:0] fdata(input int s);
        return (s == 0) ? 64'd0 : stg[(s - 1) * XLEN +: XLEN];
    endfunction

    task automatic compare();
        int a1, a2, b1, b2;
        predict(qa, 1, st_a, a1, a2);
        predict(qb, 2, st_b, b1, b2);
        chk("a_stall", 64'(ia.stall), 64'(st_a));
        chk("a_flush_ifid", 64'(ia.flush_ifid), 64'(c_redir));
        chk("a_flush_idex", 64'(ia.flush_idex), 64'(c_redir));
        chk("a_sel1", 64'(ia.fwd_sel1), 64'(a1));
        chk("a_sel2", 64'(ia.fwd_sel2), 64'(a2));
        chk("a_data1", ia.fwd_data1, fdata(a1));
        chk("a_data2", ia.fwd_data2, fdata(a2));
        chk("b_stall", 64'(ib.stall), 64'(st_b));
        chk("b_flush_ifid", 64'(ib.flush_ifid), 64'(c_redir));
        chk("b_sel1", 64'(ib.fwd_sel1), 64'(b1));
        chk("b_sel2", 64'(ib.fwd_sel2), 64'(b2));
        chk("b_data1", ib.fwd_data1, fdata(b1));
        chk("b_data2", ib.fwd_data2, fdata(b2));
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit rw, input bit ld, input bit redir);
        c_v = v; c_rs1 = rs1; c_rs2 = rs2; c_u1 = u1; c_u2 = u2;
        c_rd = rd; c_rw = rw; c_ld = ld; c_redir = redir;
        for (int i = 0; i < NSTG * XLEN / 32; i++) stg[i*32 +: 32] = $urandom;
        ia.id_valid = v; ia.id_rs1 = RA_W'(rs1); ia.id_rs2 = RA_W'(rs2);
        ia.id_use_rs1 = u1; ia.id_use_rs2 = u2; ia.id_rd = RA_W'(rd);
        ia.id_regwrite = rw; ia.id_is_load = ld; ia.redirect = redir; ia.stg_data = stg;
        ib.id_valid = v; ib.id_rs1 = RA_W'(rs1); ib.id_rs2 = RA_W'(rs2);
        ib.id_use_rs1 = u1; ib.id_use_rs2 = u2; ib.id_rd = RA_W'(rd);
        ib.id_regwrite = rw; ib.id_is_load = ld; ib.redirect = redir; ib.stg_data = stg;
        #1;
        compare();
    endtask

    task automatic adv();
        @(posedge clk);
        m_scnt = !rst_n ? 0 : m_scnt + (st_a ? 1 : 0);
        m_fcnt = !rst_n ? 0 : m_fcnt + (c_redir ? 1 : 0);
        qa = advance(qa, st_a);
        qb = advance(qb, st_b);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            adv();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ia.id_valid = 0; ib.id_valid = 0; ia.redirect = 0; ib.redirect = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_stall", 64'(ia.stall), 64'd0);
        chk("reset_sel1", 64'(ia.fwd_sel1), 64'd0);
        adv();
        // add x5 ; add x6,x5,x1 -> forward from EX
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0); adv();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("ex_fwd_sel1", 64'(ia.fwd_sel1), 64'd1);
        chk("ex_fwd_stall", 64'(ia.stall), 64'd0);
        chk("ex_fwd_data1", ia.fwd_data1, stg[63:0]);
        adv();
        idle(3);
        // ld x5 ; add x6,x5,x0 repeated while stalled
        drive(1, 1, 0, 1, 0, 5, 1, 1, 0); adv();
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0);
        chk("lu_a_stall0", 64'(ia.stall), 64'd1);
        chk("lu_b_stall0", 64'(ib.stall), 64'd1);
        adv();
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0);
        chk("lu_a_stall1", 64'(ia.stall), 64'd0);
        chk("lu_a_sel_mem", 64'(ia.fwd_sel1), 64'd2);
        chk("lu_b_stall1", 64'(ib.stall), 64'd1);
        adv();
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0);
        chk("lu_b_stall2", 64'(ib.stall), 64'd0);
        chk("lu_b_sel_wb", 64'(ib.fwd_sel1), 64'd3);
        adv();
        idle(3);
        // x5 in stages 1 and 3 -> youngest wins; x0 writer is never tracked
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); adv();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0); adv();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); adv();
        drive(1, 5, 7, 1, 1, 0, 1, 1, 0);
        chk("young_sel1", 64'(ia.fwd_sel1), 64'd1);
        chk("young_sel2", 64'(ia.fwd_sel2), 64'd2);
        adv();
        drive(1, 0, 0, 1, 1, 9, 1, 0, 0);
        chk("x0_sel1", 64'(ia.fwd_sel1), 64'd0);
        chk("x0_stall", 64'(ia.stall), 64'd0);
        adv();
        idle(3);
        // redirect with dependent load in stage 1
        drive(1, 1, 0, 1, 0, 5, 1, 1, 0); adv();
        drive(1, 5, 0, 1, 0, 6, 1, 0, 1);
        chk("br_stall", 64'(ia.stall), 64'd0);
        chk("br_flush_ifid", 64'(ia.flush_ifid), 64'd1);
        chk("br_flush_idex", 64'(ia.flush_idex), 64'd1);
        adv();
        drive(1, 5, 0, 1, 0, 6, 1, 0, 0);
        chk("br_squashed_sel", 64'(ia.fwd_sel1), 64'd0);
        chk("br_squashed_stall", 64'(ia.stall), 64'd0);
        adv();
        idle(3);
        // reset with three writers in flight
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0); adv();
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0); adv();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0); adv();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); adv();
        rst_n = 1'b1;
        drive(1, 5, 7, 1, 1, 0, 0, 0, 0);
        chk("rst_sel1", 64'(ia.fwd_sel1), 64'd0);
        chk("rst_sel2", 64'(ia.fwd_sel2), 64'd0);
        chk("rst_stall", 64'(ia.stall), 64'd0);
        adv();
        for (int n = 0; n < 600; n++) begin
            rst_n = $urandom_range(0, 49) != 0;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            adv();
        end
        rst_n = 1'b1;
        idle(2);
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cnt", 64'(ia.stall_cnt), 64'(m_scnt));
        chk("flush_cnt", 64'(ia.flush_cnt), 64'(m_fcnt));
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
